data_bus_responder: RTL and testbench

- Responder end of the CPU data-memory bus; the CPU is the initiator.
- Sits between the CPU core and the outside world. Serves word-addressed RAM plus a small memory-mapped I/O page:
  - LED register
  - free-running cycle counter
  - byte-wide TX FIFO with a valid/ready console output
  - TX status register
- Read data is registered, giving one-cycle read latency, which matches the CPU's LOAD writeback timing.

---
 rtl/data_bus_responder.sv | 112 +++++++++++
 tb/tb_data_bus_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-memory bus responder: word RAM plus an I/O page with LED, cycle counter
// and a byte-wide TX FIFO. All reads are registered (one-cycle latency, read-first).
module data_bus_responder #(
  parameter int RAM_WORDS   = 4096,
  parameter int FIFO_DEPTH  = 4,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] dataAddress,
  input  logic [31:0] dataOut,
  input  logic        dataWrEn,
  output logic [31:0] dataIn,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  led
);

  localparam logic [13:0] ADDR_LED    = 14'h3FF0;
  localparam logic [13:0] ADDR_CYCLES = 14'h3FF1;
  localparam logic [13:0] ADDR_TXDATA = 14'h3FF2;
  localparam logic [13:0] ADDR_STATUS = 14'h3FF3;

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int RAW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]            ram_q [RAM_WORDS];
  logic [7:0]             fifo_q [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             led_q, led_d;
  logic [CYCLE_WIDTH-1:0] cyc_q;
  logic [31:0]            data_in_q, data_in_d;

  logic           ram_hit, wr_fire, full, empty, push, pop;
  logic [RAW-1:0] ram_idx;
  logic [31:0]    status;

  assign ram_hit = {18'd0, dataAddress} < 32'(RAM_WORDS);
  assign ram_idx = dataAddress[RAW-1:0];
  assign wr_fire = dataWrEn && !rst;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // Fullness is judged on pre-edge occupancy, so a same-edge pop never rescues a push.
  assign push    = wr_fire && (dataAddress == ADDR_TXDATA) && !full;
  assign pop     = !empty && tx_ready;
  assign status  = {24'd0, 4'(count_q), 1'b0, ovf_q, full, empty};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    data_in_d = '0;
    if (ram_hit) begin
      data_in_d = ram_q[ram_idx];
    end else begin
      case (dataAddress)
        ADDR_LED:    data_in_d = {24'd0, led_q};
        ADDR_CYCLES: data_in_d = 32'(cyc_q);
        ADDR_STATUS: data_in_d = status;
        default:     data_in_d = '0;
      endcase
    end
  end

  always_comb begin
    led_d    = led_q;
    ovf_d    = ovf_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (wr_fire && dataAddress == ADDR_LED) led_d = dataOut[7:0];
    if (wr_fire && dataAddress == ADDR_TXDATA && full) ovf_d = 1'b1;
    else if (wr_fire && dataAddress == ADDR_STATUS)    ovf_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments; this also makes every
  // read see pre-edge values, which is what gives read-first collision behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_in_q <= '0;
      led_q     <= '0;
      cyc_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      data_in_q <= data_in_d;
      led_q     <= led_d;
      cyc_q     <= cyc_q + CYCLE_WIDTH'(1);
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; RAM survives rst and FIFO
  // slots are only visible through the reset pointers/count.
  always_ff @(posedge clk) begin
    if (wr_fire && ram_hit) ram_q[ram_idx] <= dataOut;
    if (push)               fifo_q[wr_ptr_q] <= dataOut[7:0];
  end

  assign dataIn   = data_in_q;
  assign led      = led_q;
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: vector table for the single-cycle
// paths, hand sequences for counter, FIFO and reset corner cases.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] dataAddress;
  logic [31:0] dataOut;
  logic        dataWrEn;
  logic        tx_ready;
  logic [31:0] dataIn, dataIn4;
  logic [7:0]  tx_data, tx_data4, led, led4;
  logic        tx_valid, tx_valid4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_responder dut (
    .clk(clk), .rst(rst), .dataAddress(dataAddress), .dataOut(dataOut),
    .dataWrEn(dataWrEn), .dataIn(dataIn), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .led(led)
  );

  data_bus_responder #(.RAM_WORDS(16), .FIFO_DEPTH(4), .CYCLE_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .dataAddress(dataAddress), .dataOut(dataOut),
    .dataWrEn(dataWrEn), .dataIn(dataIn4), .tx_data(tx_data4),
    .tx_valid(tx_valid4), .tx_ready(tx_ready), .led(led4)
  );

  typedef struct {
    logic        rst;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_led;
    logic [7:0]  exp_led;
    logic        chk_idle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic [13:0] a, logic [31:0] d, logic w,
                             logic cr, logic [31:0] er, logic cl, logic [7:0] el,
                             logic ci);
    vec_t t;
    t.rst = r; t.addr = a; t.wdata = d; t.we = w;
    t.chk_rd = cr; t.exp_rd = er; t.chk_led = cl; t.exp_led = el; t.chk_idle = ci;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [13:0] a, input logic [31:0] d,
                       input logic w, input logic txr);
    rst = r; dataAddress = a; dataOut = d; dataWrEn = w; tx_ready = txr;
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 14'h0, 32'h0, 1'b0, 1'b0);

    vecs.push_back(v(1, 14'h0000, 32'h0,        0, 1, 32'h0,        1, 8'h00, 1));
    vecs.push_back(v(1, 14'h0000, 32'h0,        0, 1, 32'h0,        1, 8'h00, 1));
    vecs.push_back(v(0, 14'h3FF0, 32'h0,        0, 1, 32'h0,        1, 8'h00, 1));
    vecs.push_back(v(0, 14'h3FF3, 32'h0,        0, 1, 32'h1,        1, 8'h00, 1));
    vecs.push_back(v(0, 14'h0005, 32'hDEADBEEF, 1, 0, 32'h0,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h0005, 32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h00, 0));
    vecs.push_back(v(0, 14'h3FF0, 32'h1A5,      1, 1, 32'h0,        1, 8'hA5, 0));
    vecs.push_back(v(0, 14'h3FF0, 32'h0,        0, 1, 32'hA5,       1, 8'hA5, 0));
    vecs.push_back(v(0, 14'h2000, 32'h0,        0, 1, 32'h0,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h0007, 32'h1,        1, 0, 32'h0,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h0007, 32'h2,        1, 1, 32'h1,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h0007, 32'h0,        0, 1, 32'h2,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h0FFF, 32'hCAFEF00D, 1, 0, 32'h0,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h0FFF, 32'h0,        0, 1, 32'hCAFEF00D, 0, 8'h00, 0));
    vecs.push_back(v(0, 14'h1000, 32'h11,       1, 1, 32'h0,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h1000, 32'h0,        0, 1, 32'h0,        0, 8'h00, 0));
    vecs.push_back(v(0, 14'h3FF2, 32'h0,        0, 1, 32'h0,        0, 8'h00, 1));
    vecs.push_back(v(0, 14'h3FFF, 32'hFFFFFF77, 1, 1, 32'h0,        1, 8'hA5, 1));
    vecs.push_back(v(0, 14'h3FF0, 32'h0,        0, 1, 32'hA5,       1, 8'hA5, 0));
    vecs.push_back(v(1, 14'h3FF0, 32'h33,       1, 1, 32'h0,        1, 8'h00, 1));
    vecs.push_back(v(1, 14'h0005, 32'h0,        1, 1, 32'h0,        1, 8'h00, 1));
    vecs.push_back(v(0, 14'h0005, 32'h0,        0, 1, 32'hDEADBEEF, 1, 8'h00, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0);
      tick();
      if (vecs[i].chk_rd)   check($sformatf("vec%0d_dataIn", i), dataIn, vecs[i].exp_rd);
      if (vecs[i].chk_led)  check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
      if (vecs[i].chk_idle) check($sformatf("vec%0d_tx_valid", i), {31'd0, tx_valid}, 32'h0);
    end

    // Cycle counter: first read after reset returns 0; 4-bit instance wraps 15->0.
    drive(1'b1, 14'h3FF1, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 14'h3FF1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("cycles32_%0d", i), dataIn, 32'(i));
      check($sformatf("cycles4_%0d", i), dataIn4, 32'(i % 16));
    end

    // Fill with tx_ready low; fifth push overflows, head stays 0x41.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 14'h3FF2, 32'h41 + 32'(k), 1'b1, 1'b0);
      tick();
      check($sformatf("fill%0d_valid", k), {31'd0, tx_valid}, 32'h1);
      check($sformatf("fill%0d_head", k), {24'd0, tx_data}, 32'h41);
    end
    drive(1'b0, 14'h3FF3, 32'h0, 1'b0, 1'b0);
    tick();
    check("status_full_ovf", dataIn, 32'h46);
    drive(1'b0, 14'h3FF3, 32'h0, 1'b1, 1'b0);
    tick();
    check("status_clear_readfirst", dataIn, 32'h46);
    drive(1'b0, 14'h3FF3, 32'h0, 1'b0, 1'b0);
    tick();
    check("status_cleared", dataIn, 32'h42);

    drive(1'b0, 14'h2000, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_valid", k), {31'd0, tx_valid}, 32'h1);
      check($sformatf("drain%0d_data", k), {24'd0, tx_data}, 32'h41 + 32'(k));
      tick();
    end
    check("drain_empty_valid", {31'd0, tx_valid}, 32'h0);
    check("drain_empty_data", {24'd0, tx_data}, 32'h0);

    // Push and pop on one edge with two entries held: count stays 2.
    drive(1'b0, 14'h3FF2, 32'h50, 1'b1, 1'b0); tick();
    drive(1'b0, 14'h3FF2, 32'h51, 1'b1, 1'b0); tick();
    drive(1'b0, 14'h3FF2, 32'h52, 1'b1, 1'b1); tick();
    drive(1'b0, 14'h3FF3, 32'h0,  1'b0, 1'b0); tick();
    check("pushpop_status", dataIn, 32'h20);
    check("pushpop_head", {24'd0, tx_data}, 32'h51);

    // Push while full with a same-edge pop: dropped and overflow set.
    drive(1'b0, 14'h3FF2, 32'h53, 1'b1, 1'b0); tick();
    drive(1'b0, 14'h3FF2, 32'h54, 1'b1, 1'b0); tick();
    drive(1'b0, 14'h3FF2, 32'h55, 1'b1, 1'b1); tick();
    drive(1'b0, 14'h3FF3, 32'h0,  1'b0, 1'b0); tick();
    check("fullpop_status", dataIn, 32'h34);
    check("fullpop_head", {24'd0, tx_data}, 32'h52);
    drive(1'b0, 14'h2000, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("fullpop_drain%0d", k), {24'd0, tx_data}, 32'h52 + 32'(k));
      tick();
    end
    check("fullpop_empty", {31'd0, tx_valid}, 32'h0);

    // Reset in the middle of a drain empties the FIFO.
    drive(1'b0, 14'h3FF2, 32'h60, 1'b1, 1'b0); tick();
    drive(1'b0, 14'h3FF2, 32'h61, 1'b1, 1'b0); tick();
    drive(1'b0, 14'h2000, 32'h0,  1'b0, 1'b1); tick();
    check("middrain_head", {24'd0, tx_data}, 32'h61);
    drive(1'b1, 14'h2000, 32'h0, 1'b0, 1'b1); tick();
    check("rst_middrain_valid", {31'd0, tx_valid}, 32'h0);
    check("rst_middrain_data", {24'd0, tx_data}, 32'h0);
    drive(1'b0, 14'h3FF3, 32'h0, 1'b0, 1'b0); tick();
    check("rst_middrain_status", dataIn, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
